// File: rtl/adc_frame_sequencer_if.sv
// Valid/ready stream carrying one frame: a header word, then the enabled channel words.
interface adc_frame_sequencer_if #(
    parameter int unsigned DW = 16
);
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          OUT_LAST;

    modport master (output OUT_DATA, output OUT_VALID, output OUT_LAST, input OUT_READY);
    modport slave  (input OUT_DATA, input OUT_VALID, input OUT_LAST, output OUT_READY);
endinterface

// File: rtl/adc_frame_sequencer.sv
// Snapshots the 16 ADC channel words on each sample strobe and serialises them as
// header + enabled channels onto one stream, for a programmed number of frames.
module adc_frame_sequencer #(
    parameter int unsigned   NUM_CH = 16,
    parameter int unsigned   DW     = 16,
    parameter logic [DW-1:0] HEADER = 16'hA5A5
) (
    input  logic                 CLK_20M,
    input  logic                 RESET_n,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [15:0]          FRAME_NUM,
    input  logic [NUM_CH-1:0]    CH_EN,
    input  logic                 SAMPLE_STB,
    input  logic [NUM_CH*DW-1:0] DATA_IN,
    adc_frame_sequencer_if.master out_if,
    output logic                 BUSY,
    output logic                 OVERRUN,
    output logic [15:0]          FRAME_CNT
);
    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_STB, S_HEADER, S_CHAN} state_e;

    state_e                    state_q, state_d;
    logic [NUM_CH-1:0][DW-1:0] snap_q, snap_d;
    logic [NUM_CH-1:0]         mask_q, mask_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [CW-1:0]             frame_num_q, frame_num_d;
    logic [CW-1:0]             frame_cnt_q, frame_cnt_d;
    logic                      stop_q, stop_d;
    logic                      overrun_q, overrun_d;
    logic                      busy_q, busy_d;
    logic [DW-1:0]             out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;

    logic                      xfer;
    logic [SW-1:0]             search_base;
    logic [PW-1:0]             nxt_idx;
    logic [PW-1:0]             hi_idx;
    logic [CW-1:0]             cnt_inc;

    assign xfer    = out_valid_q && out_if.OUT_READY;
    assign cnt_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + CW'(1);

    // Priority search: next enabled channel above the current pointer, and the highest enabled one.
    always_comb begin
        search_base = (state_q == S_HEADER) ? '0 : SW'(ptr_q) + SW'(1);
        nxt_idx     = '0;
        hi_idx      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (SW'(i) >= search_base)) nxt_idx = PW'(i);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask_q[i]) hi_idx = PW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        frame_num_d = frame_num_q;
        frame_cnt_d = frame_cnt_q;
        stop_d      = stop_q;
        overrun_d   = overrun_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (START && (FRAME_NUM != '0)) begin
                    frame_num_d = FRAME_NUM;
                    mask_d      = CH_EN;
                    frame_cnt_d = '0;
                    overrun_d   = 1'b0;
                    stop_d      = 1'b0;
                    state_d     = S_WAIT_STB;
                end
            end
            S_WAIT_STB: begin
                // A strobe beats a simultaneous STOP; the STOP then ends the run after this frame.
                if (SAMPLE_STB) begin
                    snap_d      = DATA_IN;
                    stop_d      = STOP;
                    out_valid_d = 1'b1;
                    out_data_d  = HEADER;
                    out_last_d  = (mask_q == '0);
                    state_d     = S_HEADER;
                end else if (STOP) begin
                    state_d = S_IDLE;
                end
            end
            S_HEADER, S_CHAN: begin
                if (SAMPLE_STB) overrun_d = 1'b1;
                if (STOP)       stop_d    = 1'b1;
                if (xfer) begin
                    if (out_last_q) begin
                        frame_cnt_d = cnt_inc;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        stop_d      = 1'b0;
                        state_d     = ((cnt_inc == frame_num_q) || stop_q || STOP) ? S_IDLE : S_WAIT_STB;
                    end else begin
                        ptr_d      = nxt_idx;
                        out_data_d = snap_q[nxt_idx];
                        out_last_d = (nxt_idx == hi_idx);
                        state_d    = S_CHAN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK_20M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= S_IDLE;
            snap_q      <= '0;
            mask_q      <= '0;
            ptr_q       <= '0;
            frame_num_q <= '0;
            frame_cnt_q <= '0;
            stop_q      <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            frame_num_q <= frame_num_d;
            frame_cnt_q <= frame_cnt_d;
            stop_q      <= stop_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_if.OUT_DATA  = out_data_q;
    assign out_if.OUT_VALID = out_valid_q;
    assign out_if.OUT_LAST  = out_last_q;
    assign BUSY             = busy_q;
    assign OVERRUN          = overrun_q;
    assign FRAME_CNT        = frame_cnt_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Bench for adc_frame_sequencer: table-driven acquisitions, directed corner cases and
// random traffic, all scored against a frame-level model of the expected stream.
module tb_adc_frame_sequencer;
    localparam int unsigned NUM_CH = 16;
    localparam int unsigned DW     = 16;
    localparam logic [15:0] HDR    = 16'hA5A5;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         stb;
    logic [15:0]  frame_num;
    logic [15:0]  ch_en;
    logic [255:0] data_in;
    logic         busy;
    logic         overrun;
    logic [15:0]  frame_cnt;

    adc_frame_sequencer_if #(.DW(DW)) bus ();

    adc_frame_sequencer #(.NUM_CH(NUM_CH), .DW(DW), .HEADER(HDR)) dut (
        .CLK_20M    (clk),
        .RESET_n    (rst_n),
        .START      (start),
        .STOP       (stop),
        .FRAME_NUM  (frame_num),
        .CH_EN      (ch_en),
        .SAMPLE_STB (stb),
        .DATA_IN    (data_in),
        .out_if     (bus),
        .BUSY       (busy),
        .OVERRUN    (overrun),
        .FRAME_CNT  (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame-level model: an acquisition is active; accepted strobes queue a whole frame of words.
    bit           m_active;
    bit           m_ovr;
    bit           m_stop;
    logic [15:0]  m_num;
    logic [15:0]  m_cnt;
    logic [15:0]  m_mask;
    logic [16:0]  exp_q[$];

    int n_vec;
    int n_err;
    int n_words;
    int rdy_mode;

    typedef struct {
        logic [15:0] fnum;
        logic [15:0] chen;
        int          rmode;
        int          nstb;
        logic [15:0] exp_cnt;
        int          exp_words;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] pattern(input int s);
        logic [255:0] d;
        for (int i = 0; i < 16; i++) d[16*i +: 16] = {4{4'(i + 1)}} ^ {8'(s), 8'(s)};
        return d;
    endfunction

    task automatic push_frame();
        int hi;
        hi = -1;
        for (int i = 0; i < 16; i++) if (m_mask[i]) hi = i;
        exp_q.push_back({hi < 0, HDR});
        for (int i = 0; i < 16; i++)
            if (m_mask[i]) exp_q.push_back({i == hi, data_in[16*i +: 16]});
    endtask

    // One clock: apply the model to the inputs/handshake seen before the edge, then check after it.
    task automatic tick();
        logic [16:0] e;
        if (rdy_mode == 1)      bus.OUT_READY = ~bus.OUT_READY;
        else if (rdy_mode == 2) bus.OUT_READY = 1'($urandom_range(0, 1));

        if (!m_active) begin
            if (start && frame_num != 16'h0) begin
                m_active = 1'b1;
                m_num    = frame_num;
                m_mask   = ch_en;
                m_cnt    = 16'h0;
                m_ovr    = 1'b0;
                m_stop   = 1'b0;
            end
        end else if (exp_q.size() == 0) begin
            if (stb) begin
                push_frame();
                m_stop = stop;
            end else if (stop) begin
                m_active = 1'b0;
            end
        end else begin
            if (stb)  m_ovr  = 1'b1;
            if (stop) m_stop = 1'b1;
            if (bus.OUT_VALID && bus.OUT_READY) begin
                e = exp_q.pop_front();
                n_words++;
                if (e[16]) begin
                    if (m_cnt != 16'hFFFF) m_cnt++;
                    if (m_cnt == m_num || m_stop) m_active = 1'b0;
                    m_stop = 1'b0;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(m_active));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("out_valid", 32'(bus.OUT_VALID), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_data", 32'(bus.OUT_DATA), 32'(exp_q[0][15:0]));
            chk("out_last", 32'(bus.OUT_LAST), 32'(exp_q[0][16]));
        end
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            tick();
            k++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_start(input logic [15:0] fn, input logic [15:0] ce);
        frame_num = fn;
        ch_en     = ce;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        frame_num = 16'($urandom);
        ch_en     = 16'($urandom);
    endtask

    task automatic pulse_stb(input logic [255:0] d);
        data_in = d;
        stb     = 1'b1;
        tick();
        stb     = 1'b0;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_last", 32'(bus.OUT_LAST), 32'd0);
        chk("rst_data", 32'(bus.OUT_DATA), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        m_active = 1'b0;
        m_ovr    = 1'b0;
        m_stop   = 1'b0;
        m_cnt    = 16'h0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{fnum: 16'd2, chen: 16'h0005, rmode: 0, nstb: 2, exp_cnt: 16'd2, exp_words: 6};
        vecs[1] = '{fnum: 16'd1, chen: 16'h8001, rmode: 1, nstb: 1, exp_cnt: 16'd1, exp_words: 3};
        vecs[2] = '{fnum: 16'd1, chen: 16'h0000, rmode: 0, nstb: 1, exp_cnt: 16'd1, exp_words: 1};
        vecs[3] = '{fnum: 16'd3, chen: 16'hFFFF, rmode: 2, nstb: 3, exp_cnt: 16'd3, exp_words: 51};
        vecs[4] = '{fnum: 16'd2, chen: 16'h00F0, rmode: 1, nstb: 2, exp_cnt: 16'd2, exp_words: 10};

        n_vec = 0; n_err = 0; n_words = 0; rdy_mode = 0;
        m_active = 1'b0; m_ovr = 1'b0; m_stop = 1'b0;
        m_num = 16'h0; m_cnt = 16'h0; m_mask = 16'h0;
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; stb = 1'b0;
        frame_num = 16'h0; ch_en = 16'h0; data_in = '0;
        bus.OUT_READY = 1'b1;
        #2;
        async_reset();

        // Table-driven acquisitions.
        for (int v = 0; v < 5; v++) begin
            rdy_mode      = vecs[v].rmode;
            bus.OUT_READY = 1'b1;
            n_words       = 0;
            pulse_start(vecs[v].fnum, vecs[v].chen);
            for (int s = 0; s < vecs[v].nstb; s++) begin
                wait_empty();
                pulse_stb(pattern(s));
            end
            wait_empty();
            tick();
            chk("tbl_frame_cnt", 32'(frame_cnt), 32'(vecs[v].exp_cnt));
            chk("tbl_busy", 32'(busy), 32'd0);
            chk("tbl_words", 32'(n_words), 32'(vecs[v].exp_words));
            chk("tbl_overrun", 32'(overrun), 32'd0);
        end

        // Second strobe while the header is stalled is dropped and flagged.
        rdy_mode = 0;
        bus.OUT_READY = 1'b0;
        pulse_start(16'd1, 16'hFFFF);
        pulse_stb(pattern(5));
        pulse_stb(pattern(9));
        chk("ovr_set", 32'(overrun), 32'd1);
        for (int k = 0; k < 3; k++) tick();
        bus.OUT_READY = 1'b1;
        wait_empty();
        tick();
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_busy", 32'(busy), 32'd0);
        pulse_start(16'd1, 16'h0000);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        pulse_stb(pattern(2));
        wait_empty();

        // STOP mid-frame 3 of 10 ends after that frame.
        pulse_start(16'd10, 16'h0003);
        for (int f = 0; f < 2; f++) begin
            pulse_stb(pattern(f));
            wait_empty();
        end
        pulse_stb(pattern(3));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_empty();
        tick();
        chk("stop_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("stop_busy", 32'(busy), 32'd0);

        // STOP while waiting for a strobe returns to idle with no output.
        n_words = 0;
        pulse_start(16'd10, 16'h0003);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stopw_busy", 32'(busy), 32'd0);
        chk("stopw_valid", 32'(bus.OUT_VALID), 32'd0);
        pulse_stb(pattern(7));
        tick();
        chk("stopw_words", 32'(n_words), 32'd0);

        // Reset in the middle of channel words, then a clean run.
        pulse_start(16'd2, 16'hFFFF);
        pulse_stb(pattern(4));
        tick();
        tick();
        chk("pre_rst_valid", 32'(bus.OUT_VALID), 32'd1);
        async_reset();
        pulse_start(16'd1, 16'h0101);
        pulse_stb(pattern(6));
        wait_empty();
        tick();
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Random traffic against the model.
        rdy_mode = 2;
        for (int k = 0; k < 4000; k++) begin
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            stb       = ($urandom_range(0, 3) == 0);
            frame_num = 16'($urandom_range(0, 3));
            ch_en     = 16'($urandom);
            for (int w = 0; w < 8; w++) data_in[32*w +: 32] = $urandom;
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
        stb   = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
- Sequences readout of the 16-channel LTC2203 capture datapath.
- On each sample strobe, snapshots all 16 channel words (already in the CLK_20M domain, after register/mean stage) and serialises them as one frame onto a single 16-bit valid/ready stream: header word first, then enabled channels in ascending order.
- Acquires a programmed number of frames per START, then returns to idle.
- Flags strobes that arrive while a frame is still draining.

Parameters:
NUM_CH, 16, number of ADC channels (U10..U25 map to channel 0..15)
DW, 16, sample width
HEADER, 16'hA5A5, frame header word

Ports:
CLK_20M  in  1  system clock
RESET_n  in  1  reset, asynchronous, active-low
START  in  1  one-cycle pulse; begins an acquisition
STOP  in  1  one-cycle pulse; ends acquisition at the next frame boundary
FRAME_NUM  in  16  frames per acquisition, sampled at START
CH_EN  in  16  channel enable mask, sampled at START; bit i = channel i
SAMPLE_STB  in  1  one-cycle strobe: DATA_IN holds a new sample set
DATA_IN  in  256  channel i on bits [16i+15:16i]
OUT_DATA  out  16  stream data
OUT_VALID  out  1  stream valid
OUT_READY  in  1  stream ready
OUT_LAST  out  1  high on the final word of a frame
BUSY  out  1  high in any state except IDLE
OVERRUN  out  1  sticky: a strobe was dropped
FRAME_CNT  out  16  frames completed in the current or last acquisition

Behaviour:

Reset and register rules
- Reset (async, RESET_n=0): state IDLE; OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, BUSY=0, OVERRUN=0, FRAME_CNT=0; snapshot, mask and channel pointer cleared.
- RESET_n asserted mid-frame aborts immediately. No partial word is held after release.
- All outputs are registered.
- A transfer occurs on a clock edge where OUT_VALID=1 and OUT_READY=1.
- While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_LAST hold stable.

States
- IDLE
  - On START with FRAME_NUM≠0: latch FRAME_NUM and CH_EN, clear FRAME_CNT and OVERRUN, go to WAIT_STB.
  - START with FRAME_NUM=0 is ignored.
  - STOP has no effect.
- WAIT_STB
  - On SAMPLE_STB: copy DATA_IN to the snapshot, go to HEADER.
  - OUT_VALID=1 with OUT_DATA=HEADER in the next cycle, i.e. 1-cycle latency from strobe to valid.
  - STOP here (without a simultaneous SAMPLE_STB) returns to IDLE next cycle.
  - STOP together with SAMPLE_STB: the strobe wins and the frame is sent, then go to IDLE.
- HEADER
  - Drives HEADER.
  - On transfer: if mask≠0, go to CHAN with pointer = lowest set bit.
  - If mask=0, the header carries OUT_LAST=1 and the frame ends.
- CHAN
  - Drives snapshot[pointer].
  - On transfer, pointer moves to the next set mask bit above the current one (priority search; disabled channels cost no cycles).
  - OUT_LAST=1 on the word for the highest set bit.
  - Back-to-back transfers are possible: one word per cycle while OUT_READY=1.

Frame end (transfer with OUT_LAST=1)
- FRAME_CNT increments.
- If FRAME_CNT (new value) == latched FRAME_NUM, or a STOP was seen during the frame: go to IDLE, OUT_VALID=0.
- Otherwise go to WAIT_STB.
- FRAME_CNT saturates at 16'hFFFF and holds its value in IDLE.

Overrun and ignored inputs
- SAMPLE_STB in HEADER or CHAN: the strobe is dropped, OVERRUN is set, and the snapshot is unchanged.
- OVERRUN clears only on an accepted START or reset.
- A SAMPLE_STB on the same edge as the frame's last transfer is also dropped (overrun).
- START while BUSY=1 is ignored.
- CH_EN/FRAME_NUM changes while BUSY=1 have no effect.
- STOP during HEADER/CHAN is latched until the frame boundary.

Test Plan:
1. Reset, then START with FRAME_NUM=2, CH_EN=16'h0005, OUT_READY=1; SAMPLE_STB with ch0=16'h1111, ch2=16'h3333 -> stream A5A5, 1111, 3333(LAST). Second strobe -> same pattern. Then BUSY=0, FRAME_CNT=2.
2. CH_EN=16'h8001, OUT_READY toggling 1/0 each cycle -> words A5A5, ch0, ch15(LAST). Each word is held stable while OUT_READY=0; no duplicates or losses.
3. CH_EN=0, FRAME_NUM=1, one strobe -> single word A5A5 with OUT_LAST=1, then IDLE, FRAME_CNT=1.
4. CH_EN=16'hFFFF, OUT_READY=0 held; second SAMPLE_STB during HEADER -> OVERRUN=1. After release, the 17 words carry the first snapshot's values. OVERRUN stays 1 until the next START.
5. FRAME_NUM=10, STOP pulsed mid-frame 3 -> frame 3 completes with LAST, then IDLE, FRAME_CNT=3. STOP in WAIT_STB -> IDLE in 1 cycle, no output.
6. RESET_n low during CHAN with OUT_VALID=1 -> OUT_VALID, BUSY, FRAME_CNT, OVERRUN are 0 immediately (asynchronously); a START after release runs normally.
